debug_panel: RTL and testbench
==============================

# debug_panel

Parametrised on-board debug display manager for the NES-on-chip board. It multiplexes N_PAGES packed words of CPU/system state onto N_DIGITS rotated 7-segment digits, and selects the page from a debounced KEY button or an auto-rotate timer. A second key freezes a snapshot of all inputs. Flags, a page indicator and a heartbeat go to the green and red LEDs. It sits under `device_mgr` between the core's debug taps and the board pins.

## Interface
- N_DIGITS, 8: 7-segment digits driven; page word width PAGE_W = 4*N_DIGITS.
- N_PAGES, 4: number of selectable pages, 2..16.
- DEBOUNCE_CYC, 500000: consecutive stable cycles needed to accept a key level change.
- ROTATE_CYC, 50000000: cycles per page in auto-rotate mode.
- i_clk  in  1  system clock.
- i_rstn  in  1  reset; one clock; reset is synchronous and active-low.
- i_page_data  in  N_PAGES*PAGE_W  packed pages; page p = bits [p*PAGE_W +: PAGE_W].
- i_flags  in  8  CPU P register.
- i_fl_ry  in  1  flash ready/busy.
- i_key_next  in  1  raw KEY, active-low, asynchronous; press = advance page.
- i_key_freeze  in  1  raw KEY, active-low, asynchronous; press = toggle freeze.
- i_auto_en  in  1  raw switch, level; 1 = auto-rotate pages.
- o_HEX  out  7*N_DIGITS  segments; digit d = bits [7*d +: 7].
- o_LEDG  out  9  [7:0] = flags bit-reversed (LEDG[7]=P[0]); [8] = fl_ry.
- o_LEDR  out  18  [0] heartbeat; [1+p] one-hot current page; [17] frozen; rest 0.
- o_page  out  $clog2(N_PAGES)  current page index.
- o_frozen  out  1  freeze state.

## Operation
- Key path, per key: 2-FF synchroniser. A counter runs while the synced level differs from the `stable` level and clears when they match. When the counter reaches DEBOUNCE_CYC-1, `stable` takes the synced level and the counter clears. A stable 1→0 transition produces a one-cycle `press` pulse. Release produces no pulse.
- i_auto_en also passes through a 2-FF synchroniser. It is not debounced.
- Page register:
  - next press increments the page modulo N_PAGES; N_PAGES-1 wraps to 0.
  - With auto enabled, the rotate counter counts 0..ROTATE_CYC-1. At terminal count it advances the page and reloads 0.
  - A manual press also reloads the rotate counter to 0.
  - A press and terminal count in the same cycle advance the page by exactly one.
  - With auto disabled, the rotate counter holds at 0.
- Freeze: a freeze press toggles `frozen`.
- Snapshot register (all pages, flags, fl_ry):
  - While not frozen it loads the inputs every cycle.
  - While frozen it holds.
  - In the cycle the freeze press sets `frozen`, it still loads, so the snapshot equals the inputs sampled on the press cycle.
  - Page changes remain allowed while frozen and show frozen data.
- Display word = snapshot page[o_page]. Digit 0 shows the most significant nibble, bits [PAGE_W-1:PAGE_W-4]; digit N_DIGITS-1 shows bits [3:0]. Each nibble is decoded by `hex2sig_rotate` (active-low, rotated mounting).
- Heartbeat: `breath_led` instance drives o_LEDR[0].

## Timing
- Reset values:
  - page 0, frozen 0, rotate counter 0, debounce counters 0.
  - stable key levels 1 (released), synchronisers 1.
  - snapshot 0, so every digit shows the hex2sig_rotate code for 0.
  - o_LEDG = 0, o_LEDR = 18'h00002 plus the breath_led reset output.
- Input data to o_HEX/o_LEDG: 1 cycle (snapshot register, then combinational select and decode).
- Key press to page/freeze change:
  - 2 sync cycles + DEBOUNCE_CYC cycles of stable low, then the press pulse.
  - The register updates on the following edge.
- Bounces shorter than DEBOUNCE_CYC cycles produce no event.
- Reset mid-debounce or mid-rotate abandons the count, with no event. Reset while frozen unfreezes.
- A key held low produces exactly one press.

## Structure
- Shared package/header `debug_panel_pkg`:
  - page index constants: PG_PC_SP_IR = 0, PG_BUS, PG_PPU, PG_MAPPER.
  - default DEBOUNCE_CYC/ROTATE_CYC for 50 MHz.
  - LEDR bit positions.
- Sub-module `key_debounce`, parameter DEBOUNCE_CYC:
  - ports i_clk, i_rstn, i_key_n, o_level, o_press.
  - Instantiated twice.
- Reuses the existing `hex2sig_rotate` (N_DIGITS instances, generate loop) and `breath_led`.

## Test plan
Bench parameters: DEBOUNCE_CYC=4, ROTATE_CYC=10, N_PAGES=4, N_DIGITS=8.
- Reset, then page words 32'h12345678, 32'hDEADBEEF, 0, 0 → o_page=0, HEX0..7 decode 1..8, LEDR[1]=1, LEDR[17]=0.
- Hold next low for 10 cycles, release, repeat three more times → o_page goes 1, 2, 3, 0 (wrap), one step per press, LEDR one-hot tracks.
- Bounce next low/high every 2 cycles for 20 cycles → no page change.
- i_auto_en=1 for 45 cycles → page advances every 10 cycles. Manual press coinciding with terminal count → single increment.
- Freeze press with page0=32'hCAFE0001, then change inputs to 32'h0 → HEX still CAFE0001, LEDR[17]=1. Second press → live data one cycle later.
- i_flags=8'b0000_0001, i_fl_ry=1 → o_LEDG=9'h180. Assert i_rstn=0 while frozen → o_frozen=0, o_page=0 next cycle.

Source files
------------

// File: rtl/debug_panel_pkg.sv
// Shared constants for the board debug display manager.
package debug_panel_pkg;

    // Page indices of the standard page layout
    localparam int unsigned PG_PC_SP_IR = 0;
    localparam int unsigned PG_BUS      = 1;
    localparam int unsigned PG_PPU      = 2;
    localparam int unsigned PG_MAPPER   = 3;

    // Defaults for a 50 MHz system clock: 10 ms debounce, 1 s per page
    localparam int unsigned DEF_DEBOUNCE_CYC = 500000;
    localparam int unsigned DEF_ROTATE_CYC   = 50000000;

    // Red LED bit positions
    localparam int unsigned LEDR_HEARTBEAT = 0;
    localparam int unsigned LEDR_PAGE_BASE = 1;
    localparam int unsigned LEDR_FROZEN    = 17;

    // Digits are mounted upside down: swap a<->d, b<->e, c<->f; g stays put
    function automatic logic [6:0] seg_rotate(input logic [6:0] s);
        return {s[6], s[2:0], s[5:3]};
    endfunction

endpackage

// File: rtl/breath_led.sv
// Heartbeat LED whose PWM duty ramps up and down continuously.
module breath_led #(
    parameter int unsigned PRESC_W = 16
) (
    input  logic i_clk,
    input  logic i_rstn,
    output logic o_led
);

    logic [PRESC_W-1:0] presc;
    logic [7:0]         pwm;
    logic [7:0]         duty;
    logic               dir_up;

    // Free-running PWM; duty steps once per prescaler wrap
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            presc  <= '0;
            pwm    <= '0;
            duty   <= '0;
            dir_up <= 1'b1;
            o_led  <= 1'b0;
        end else begin
            presc <= presc + 1'b1;
            pwm   <= pwm + 1'b1;
            o_led <= (pwm < duty);
            if (presc == '1) begin
                if (dir_up) begin
                    if (duty == 8'hFE) dir_up <= 1'b0;
                    duty <= duty + 1'b1;
                end else begin
                    if (duty == 8'h01) dir_up <= 1'b1;
                    duty <= duty - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hex2sig_rotate.sv
// Hex nibble to active-low 7-segment code for an upside-down mounted digit.
module hex2sig_rotate
    import debug_panel_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_sig
);

    logic [6:0] upright;

    // Upright gfedcba code, then remap segments for the rotated mounting
    always_comb begin
        upright = 7'h7F;
        case (i_hex)
            4'h0: upright = 7'h40;
            4'h1: upright = 7'h79;
            4'h2: upright = 7'h24;
            4'h3: upright = 7'h30;
            4'h4: upright = 7'h19;
            4'h5: upright = 7'h12;
            4'h6: upright = 7'h02;
            4'h7: upright = 7'h78;
            4'h8: upright = 7'h00;
            4'h9: upright = 7'h10;
            4'hA: upright = 7'h08;
            4'hB: upright = 7'h03;
            4'hC: upright = 7'h46;
            4'hD: upright = 7'h21;
            4'hE: upright = 7'h06;
            4'hF: upright = 7'h0E;
            default: upright = 7'h7F;
        endcase
        o_sig = seg_rotate(upright);
    end

endmodule

// File: rtl/key_debounce.sv
// Synchroniser plus debouncer for one active-low push button.
module key_debounce
    import debug_panel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // Accept a new level only after it has been seen for DEBOUNCE_CYC cycles
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            sync    <= '1;
            cnt     <= '0;
            o_level <= 1'b1;
            o_press <= 1'b0;
        end else begin
            sync    <= {sync[0], i_key_n};
            o_press <= 1'b0;
            if (sync[1] != o_level) begin
                if (cnt == CNT_LAST) begin
                    o_level <= sync[1];
                    cnt     <= '0;
                    o_press <= ~sync[1];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/debug_panel.sv
// Debug display manager: page select, freeze snapshot, 7-segment and LED drive.
module debug_panel
    import debug_panel_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 8,
    parameter int unsigned N_PAGES      = 4,
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned ROTATE_CYC   = DEF_ROTATE_CYC,
    localparam int unsigned PAGE_W      = 4 * N_DIGITS,
    localparam int unsigned PG_W        = $clog2(N_PAGES)
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic [N_PAGES*PAGE_W-1:0]   i_page_data,
    input  logic [7:0]                  i_flags,
    input  logic                        i_fl_ry,
    input  logic                        i_key_next,
    input  logic                        i_key_freeze,
    input  logic                        i_auto_en,
    output logic [7*N_DIGITS-1:0]       o_HEX,
    output logic [8:0]                  o_LEDG,
    output logic [17:0]                 o_LEDR,
    output logic [PG_W-1:0]             o_page,
    output logic                        o_frozen
);

    localparam int unsigned RC_W = $clog2(ROTATE_CYC + 1);
    localparam logic [RC_W-1:0] ROT_LAST = RC_W'(ROTATE_CYC - 1);
    localparam logic [PG_W-1:0] PAGE_LAST = PG_W'(N_PAGES - 1);

    logic                      next_press, freeze_press;
    logic                      next_level_unused, freeze_level_unused;
    logic [1:0]                auto_sync;
    logic                      auto_on, rot_tc;
    logic [RC_W-1:0]           rot_cnt;
    logic [PG_W-1:0]           page_q;
    logic                      frozen_q;
    logic [N_PAGES*PAGE_W-1:0] snap_pages;
    logic [7:0]                snap_flags;
    logic                      snap_fl_ry;
    logic [PAGE_W-1:0]         disp_word;
    logic                      heartbeat;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_next (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_key_n (i_key_next),
        .o_level (next_level_unused),
        .o_press (next_press)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_freeze (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_key_n (i_key_freeze),
        .o_level (freeze_level_unused),
        .o_press (freeze_press)
    );

    assign auto_on = auto_sync[1];
    assign rot_tc  = auto_on && (rot_cnt == ROT_LAST);

    // Auto-rotate switch synchroniser (level only, no debounce)
    always_ff @(posedge i_clk) begin
        if (!i_rstn) auto_sync <= '0;
        else         auto_sync <= {auto_sync[0], i_auto_en};
    end

    // Page select; a press coinciding with terminal count still steps once
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            page_q  <= '0;
            rot_cnt <= '0;
        end else begin
            if (next_press || !auto_on || rot_tc) rot_cnt <= '0;
            else                                  rot_cnt <= rot_cnt + 1'b1;
            if (next_press || rot_tc)
                page_q <= (page_q == PAGE_LAST) ? '0 : page_q + 1'b1;
        end
    end

    // Freeze toggle
    always_ff @(posedge i_clk) begin
        if (!i_rstn)           frozen_q <= 1'b0;
        else if (freeze_press) frozen_q <= ~frozen_q;
    end

    // Snapshot tracks inputs until frozen; the freezing cycle itself still loads
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            snap_pages <= '0;
            snap_flags <= '0;
            snap_fl_ry <= 1'b0;
        end else if (!frozen_q) begin
            snap_pages <= i_page_data;
            snap_flags <= i_flags;
            snap_fl_ry <= i_fl_ry;
        end
    end

    // Select the displayed page word from the snapshot
    always_comb begin
        disp_word = '0;
        for (int unsigned p = 0; p < N_PAGES; p++)
            if (page_q == PG_W'(p)) disp_word = snap_pages[p*PAGE_W +: PAGE_W];
    end

    // Digit 0 carries the most significant nibble
    for (genvar d = 0; d < N_DIGITS; d++) begin : g_digit
        hex2sig_rotate u_hex (
            .i_hex (disp_word[PAGE_W-1-4*d -: 4]),
            .o_sig (o_HEX[7*d +: 7])
        );
    end

    breath_led u_breath (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .o_led  (heartbeat)
    );

    // Red LEDs: heartbeat, one-hot page, frozen flag
    always_comb begin
        o_LEDR = '0;
        o_LEDR[LEDR_HEARTBEAT] = heartbeat;
        for (int unsigned p = 0; p < N_PAGES; p++)
            o_LEDR[LEDR_PAGE_BASE + p] = (page_q == PG_W'(p));
        o_LEDR[LEDR_FROZEN] = frozen_q;
    end

    assign o_LEDG   = {snap_fl_ry, snap_flags[0], snap_flags[1], snap_flags[2], snap_flags[3],
                       snap_flags[4], snap_flags[5], snap_flags[6], snap_flags[7]};
    assign o_page   = page_q;
    assign o_frozen = frozen_q;

endmodule

// File: tb/tb_debug_panel.sv
// Randomised self-checking bench for debug_panel against a behavioural model.
module tb_debug_panel;

    localparam int unsigned N_DIGITS = 8;
    localparam int unsigned N_PAGES  = 4;
    localparam int unsigned PAGE_W   = 32;
    localparam int unsigned DEB      = 4;
    localparam int unsigned ROT      = 10;

    logic                        clk = 1'b0;
    logic                        rstn;
    logic [N_PAGES*PAGE_W-1:0]   page_data;
    logic [7:0]                  flags;
    logic                        fl_ry;
    logic                        key_next, key_freeze, auto_en;
    logic [7*N_DIGITS-1:0]       hex;
    logic [8:0]                  ledg;
    logic [17:0]                 ledr;
    logic [1:0]                  page;
    logic                        frozen;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    logic [31:0] pages_m [N_PAGES];
    logic [31:0] snap_m  [N_PAGES];
    int          exp_page;
    bit          frozen_m;

    // Page-step monitor state
    bit          mon_en = 1'b0;
    logic [1:0]  mon_prev;
    int          cyc = 0;
    int          change_times [$];

    debug_panel #(
        .N_DIGITS     (N_DIGITS),
        .N_PAGES      (N_PAGES),
        .DEBOUNCE_CYC (DEB),
        .ROTATE_CYC   (ROT)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_page_data  (page_data),
        .i_flags      (flags),
        .i_fl_ry      (fl_ry),
        .i_key_next   (key_next),
        .i_key_freeze (key_freeze),
        .i_auto_en    (auto_en),
        .o_HEX        (hex),
        .o_LEDG       (ledg),
        .o_LEDR       (ledr),
        .o_page       (page),
        .o_frozen     (frozen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Active-low codes of an upside-down digit, indexed by nibble
    function automatic logic [6:0] rot_code(input logic [3:0] n);
        logic [6:0] tab [16];
        tab = '{7'h40, 7'h4F, 7'h24, 7'h06, 7'h0B, 7'h12, 7'h10, 7'h47,
                7'h00, 7'h02, 7'h01, 7'h18, 7'h70, 7'h0C, 7'h30, 7'h31};
        return tab[n];
    endfunction

    function automatic logic [55:0] exp_hex(input logic [31:0] w);
        logic [55:0] r = '0;
        for (int unsigned d = 0; d < N_DIGITS; d++) begin
            logic [3:0] nib;
            nib = 4'((w >> (4 * (N_DIGITS - 1 - d))) & 32'hF);
            r[7*d +: 7] = rot_code(nib);
        end
        return r;
    endfunction

    function automatic logic [8:0] exp_ledg(input logic [7:0] f, input logic ry);
        logic [8:0] r;
        r[8] = ry;
        for (int unsigned i = 0; i < 8; i++) r[7 - i] = f[i];
        return r;
    endfunction

    function automatic logic [17:0] exp_ledr(input int pg, input bit fz);
        logic [17:0] r = '0;
        r[1 + pg] = 1'b1;
        r[17] = fz;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_pages();
        for (int p = 0; p < N_PAGES; p++) page_data[p*PAGE_W +: PAGE_W] = pages_m[p];
    endtask

    task automatic press_next();
        key_next = 1'b0;
        repeat (10) step();
        key_next = 1'b1;
        repeat (10) step();
    endtask

    task automatic press_freeze();
        key_freeze = 1'b0;
        repeat (10) step();
        key_freeze = 1'b1;
        repeat (10) step();
    endtask

    task automatic check_state(input string tag, input logic [31:0] word);
        check({tag, "_hex"}, 64'(hex), 64'(exp_hex(word)));
        check({tag, "_page"}, 64'(page), 64'(exp_page));
        check({tag, "_ledr"}, 64'(ledr & 18'h3FFFE), 64'(exp_ledr(exp_page, frozen_m)));
        check({tag, "_frozen"}, 64'(frozen), 64'(frozen_m));
    endtask

    // Every page change observed must be a single modulo step
    always @(negedge clk) begin
        cyc++;
        if (mon_en && page !== mon_prev) begin
            check("page_step", 64'(page), 64'((int'(mon_prev) + 1) % N_PAGES));
            change_times.push_back(cyc);
        end
        mon_prev = page;
    end

    initial begin
        rstn = 1'b0; key_next = 1'b1; key_freeze = 1'b1; auto_en = 1'b0;
        flags = 8'h00; fl_ry = 1'b0;
        pages_m = '{32'h12345678, 32'hDEADBEEF, 32'h0, 32'h0};
        apply_pages();
        exp_page = 0; frozen_m = 1'b0;
        repeat (3) step();

        // Reset state: snapshot cleared, page 0 indicated
        check_state("reset", 32'h0);
        check("reset_ledg", 64'(ledg), 64'h0);

        rstn = 1'b1;
        step();
        mon_en = 1'b1;
        check_state("live0", pages_m[0]);

        // Four manual presses, wrapping back to 0
        for (int i = 0; i < 4; i++) begin
            press_next();
            exp_page = (exp_page + 1) % N_PAGES;
            check_state("press", pages_m[exp_page]);
        end

        // Short bounces must not register
        for (int i = 0; i < 10; i++) begin
            key_next = i[0] ? 1'b1 : 1'b0;
            repeat (2) step();
        end
        key_next = 1'b1;
        repeat (10) step();
        check("bounce_page", 64'(page), 64'(exp_page));

        // Random live data: display and LEDG follow inputs after one cycle
        for (int i = 0; i < 24; i++) begin
            for (int p = 0; p < N_PAGES; p++) pages_m[p] = $urandom;
            flags = 8'($urandom);
            fl_ry = 1'($urandom);
            apply_pages();
            step();
            check("rand_hex", 64'(hex), 64'(exp_hex(pages_m[exp_page])));
            check("rand_ledg", 64'(ledg), 64'(exp_ledg(flags, fl_ry)));
            if (i % 8 == 7) begin
                press_next();
                exp_page = (exp_page + 1) % N_PAGES;
                check_state("rand_press", pages_m[exp_page]);
            end
        end
        // Three presses above; one more returns to page 0
        press_next();
        exp_page = (exp_page + 1) % N_PAGES;
        check("rand_wrap", 64'(page), 64'(exp_page));

        // Auto-rotate: one step every ROT cycles
        change_times.delete();
        auto_en = 1'b1;
        repeat (45) step();
        auto_en = 1'b0;
        repeat (6) step();
        check("auto_count", 64'(change_times.size()), 64'd4);
        if (change_times.size() >= 4)
            for (int i = 1; i < 4; i++)
                check("auto_interval", 64'(change_times[i] - change_times[i-1]), 64'(ROT));
        exp_page = (exp_page + 4) % N_PAGES;
        check("auto_page", 64'(page), 64'(exp_page));

        // Freeze: snapshot captured during the press, then held
        pages_m[0] = 32'hCAFE0001;
        for (int p = 1; p < N_PAGES; p++) pages_m[p] = $urandom;
        flags = 8'hA5; fl_ry = 1'b1;
        apply_pages();
        press_freeze();
        frozen_m = 1'b1;
        for (int p = 0; p < N_PAGES; p++) snap_m[p] = pages_m[p];
        for (int p = 0; p < N_PAGES; p++) pages_m[p] = 32'h0;
        flags = 8'h00; fl_ry = 1'b0;
        apply_pages();
        repeat (3) step();
        check_state("frozen", snap_m[0]);
        check("frozen_ledg", 64'(ledg), 64'(exp_ledg(8'hA5, 1'b1)));
        press_next();
        exp_page = 1;
        check_state("frozen_pg1", snap_m[1]);
        press_freeze();
        frozen_m = 1'b0;
        for (int p = 0; p < N_PAGES; p++) pages_m[p] = $urandom;
        apply_pages();
        step();
        check_state("unfrozen", pages_m[1]);

        // Flags bit reversal with flash ready
        flags = 8'b0000_0001; fl_ry = 1'b1;
        step();
        check("ledg_180", 64'(ledg), 64'h180);

        // Sweep press phase against terminal count; monitor enforces single steps
        change_times.delete();
        auto_en = 1'b1;
        for (int k = 0; k < ROT; k++) begin
            press_next();
            repeat (k) step();
        end
        auto_en = 1'b0;
        repeat (6) step();
        check("sweep_moved", 64'(change_times.size() >= ROT), 64'd1);

        // Reset while frozen clears freeze and page
        press_freeze();
        check("pre_rst_frozen", 64'(frozen), 64'd1);
        mon_en = 1'b0;
        rstn = 1'b0;
        step();
        check("rst_frozen", 64'(frozen), 64'd0);
        check("rst_page", 64'(page), 64'd0);
        rstn = 1'b1;
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound in case anything stalls
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
